// File: rtl/dispatch_queue.sv
// Buffered dispatch stage: a DEPTH-entry instruction FIFO whose head is dispatched into a
// registered packet once the ROB and the target unit have room, with operands resolved at fire.
module dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6,
  parameter int NCDB  = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    id_valid_in,
  output logic                    id_ready_out,
  input  logic [OP_W-1:0]         id_op_in,
  input  logic [XLEN-1:0]         id_imm_in,
  input  logic [XLEN-1:0]         id_pc_in,
  input  logic [4:0]              id_rd_in,
  input  logic [4:0]              id_rs1_in,
  input  logic [4:0]              id_rs2_in,
  input  logic                    id_use_rs1_in,
  input  logic                    id_use_rs2_in,
  input  logic                    id_is_mem_in,
  input  logic                    id_wr_rd_in,
  output logic [4:0]              reg_rs1_out,
  output logic [4:0]              reg_rs2_out,
  input  logic                    reg_rs1_busy_in,
  input  logic                    reg_rs2_busy_in,
  input  logic [XLEN-1:0]         reg_rs1_val_in,
  input  logic [XLEN-1:0]         reg_rs2_val_in,
  input  logic                    rob_rs1_ready_in,
  input  logic                    rob_rs2_ready_in,
  input  logic [XLEN-1:0]         rob_rs1_val_in,
  input  logic [XLEN-1:0]         rob_rs2_val_in,
  input  logic                    rob_full_in,
  input  logic [ROB_W-1:0]        rob_tag_in,
  output logic                    rob_alloc_out,
  output logic                    reg_wq_en_out,
  output logic [4:0]              reg_wq_rd_out,
  output logic [ROB_W-1:0]        reg_wq_tag_out,
  input  logic                    rs_full_in,
  input  logic                    lsb_full_in,
  input  logic [NCDB-1:0]         cdb_valid_in,
  input  logic [NCDB*ROB_W-1:0]   cdb_tag_in,
  input  logic [NCDB*XLEN-1:0]    cdb_data_in,
  output logic                    disp_valid_out,
  output logic                    disp_to_lsb_out,
  output logic [OP_W-1:0]         disp_op_out,
  output logic [XLEN-1:0]         disp_imm_out,
  output logic [XLEN-1:0]         disp_pc_out,
  output logic [4:0]              disp_rd_out,
  output logic [ROB_W-1:0]        disp_tag_out,
  output logic                    disp_qj_out,
  output logic                    disp_qk_out,
  output logic [XLEN-1:0]         disp_vj_out,
  output logic [XLEN-1:0]         disp_vk_out
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            is_mem;
    logic            wr_rd;
  } entry_t;

  // Returns {hit, data}; the lowest matching channel wins, so scan from the top down.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_W-1:0]      tag,
    input logic [NCDB-1:0]       cv,
    input logic [NCDB*ROB_W-1:0] ct,
    input logic [NCDB*XLEN-1:0]  cd
  );
    logic [XLEN:0] res;
    res = {1'b0, {XLEN{1'b0}}};
    for (int i = NCDB - 1; i >= 0; i--) begin
      if (cv[i] && (ct[i*ROB_W +: ROB_W] == tag)) begin
        res = {1'b1, cd[i*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  // Returns {q, v} for one operand: unused/x0, regfile, ROB, CDB, else pending on tag.
  function automatic logic [XLEN:0] resolve(
    input logic                  use_r,
    input logic [4:0]            idx,
    input logic                  busy,
    input logic [XLEN-1:0]       rval,
    input logic                  rob_rdy,
    input logic [XLEN-1:0]       rob_val,
    input logic [NCDB-1:0]       cv,
    input logic [NCDB*ROB_W-1:0] ct,
    input logic [NCDB*XLEN-1:0]  cd
  );
    logic [XLEN:0] res;
    logic [XLEN:0] hit;
    hit = cdb_lookup(rval[ROB_W-1:0], cv, ct, cd);
    if (!use_r || (idx == 5'd0)) begin
      res = {1'b0, {XLEN{1'b0}}};
    end else if (!busy) begin
      res = {1'b0, rval};
    end else if (rob_rdy) begin
      res = {1'b0, rob_val};
    end else if (hit[XLEN]) begin
      res = {1'b0, hit[XLEN-1:0]};
    end else begin
      res = {1'b1, {(XLEN-ROB_W){1'b0}}, rval[ROB_W-1:0]};
    end
    return res;
  endfunction

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              disp_valid_q, disp_valid_d, disp_to_lsb_q, disp_to_lsb_d;
  logic [OP_W-1:0]   disp_op_q, disp_op_d;
  logic [XLEN-1:0]   disp_imm_q, disp_imm_d, disp_pc_q, disp_pc_d;
  logic [4:0]        disp_rd_q, disp_rd_d;
  logic [ROB_W-1:0]  disp_tag_q, disp_tag_d;
  logic              disp_qj_q, disp_qj_d, disp_qk_q, disp_qk_d;
  logic [XLEN-1:0]   disp_vj_q, disp_vj_d, disp_vk_q, disp_vk_d;

  entry_t            head_s;
  entry_t            new_s;
  logic              push_s, fire_s, unit_free_s;
  logic [XLEN:0]     opj_s, opk_s, snoop_j_s, snoop_k_s;

  // Head lookup, handshake and operand resolution for the fire cycle.
  always_comb begin
    head_s        = mem_q[head_q];
    new_s         = '{op: id_op_in, imm: id_imm_in, pc: id_pc_in, rd: id_rd_in,
                      rs1: id_rs1_in, rs2: id_rs2_in, use_rs1: id_use_rs1_in,
                      use_rs2: id_use_rs2_in, is_mem: id_is_mem_in, wr_rd: id_wr_rd_in};
    id_ready_out  = (count_q < CNT_FULL) & ~flush_in;
    push_s        = rdy_in & id_valid_in & id_ready_out;
    unit_free_s   = head_s.is_mem ? ~lsb_full_in : ~rs_full_in;
    fire_s        = rdy_in & ~flush_in & (count_q != {(PTR_W+1){1'b0}}) & ~rob_full_in & unit_free_s;
    reg_rs1_out   = head_s.rs1;
    reg_rs2_out   = head_s.rs2;
    rob_alloc_out = fire_s;
    reg_wq_en_out = fire_s & head_s.wr_rd & (head_s.rd != 5'd0);
    reg_wq_rd_out = head_s.rd;
    reg_wq_tag_out = rob_tag_in;
    opj_s = resolve(head_s.use_rs1, head_s.rs1, reg_rs1_busy_in, reg_rs1_val_in,
                    rob_rs1_ready_in, rob_rs1_val_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
    opk_s = resolve(head_s.use_rs2, head_s.rs2, reg_rs2_busy_in, reg_rs2_val_in,
                    rob_rs2_ready_in, rob_rs2_val_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
  end

  // Next-state for FIFO pointers, storage and the dispatch packet.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[tail_q] = new_s;
    end else begin
      mem_d[tail_q] = mem_q[tail_q];
    end
    if (flush_in) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {(PTR_W+1){1'b0}};
    end else begin
      head_d  = fire_s ? head_q + PTR_ONE : head_q;
      tail_d  = push_s ? tail_q + PTR_ONE : tail_q;
      case ({push_s, fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    disp_valid_d = fire_s;
    if (fire_s) begin
      disp_to_lsb_d = head_s.is_mem;
      disp_op_d     = head_s.op;
      disp_imm_d    = head_s.imm;
      disp_pc_d     = head_s.pc;
      disp_rd_d     = head_s.rd;
      disp_tag_d    = rob_tag_in;
      disp_qj_d     = opj_s[XLEN];
      disp_vj_d     = opj_s[XLEN-1:0];
      disp_qk_d     = opk_s[XLEN];
      disp_vk_d     = opk_s[XLEN-1:0];
    end else begin
      disp_to_lsb_d = disp_to_lsb_q;
      disp_op_d     = disp_op_q;
      disp_imm_d    = disp_imm_q;
      disp_pc_d     = disp_pc_q;
      disp_rd_d     = disp_rd_q;
      disp_tag_d    = disp_tag_q;
      disp_qj_d     = disp_qj_q;
      disp_vj_d     = disp_vj_q;
      disp_qk_d     = disp_qk_q;
      disp_vk_d     = disp_vk_q;
    end
  end

  // State registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q        <= {PTR_W{1'b0}};
      tail_q        <= {PTR_W{1'b0}};
      count_q       <= {(PTR_W+1){1'b0}};
      disp_valid_q  <= 1'b0;
      disp_to_lsb_q <= 1'b0;
      disp_op_q     <= {OP_W{1'b0}};
      disp_imm_q    <= {XLEN{1'b0}};
      disp_pc_q     <= {XLEN{1'b0}};
      disp_rd_q     <= 5'd0;
      disp_tag_q    <= {ROB_W{1'b0}};
      disp_qj_q     <= 1'b0;
      disp_vj_q     <= {XLEN{1'b0}};
      disp_qk_q     <= 1'b0;
      disp_vk_q     <= {XLEN{1'b0}};
    end else if (rdy_in) begin
      mem_q         <= mem_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      disp_valid_q  <= disp_valid_d;
      disp_to_lsb_q <= disp_to_lsb_d;
      disp_op_q     <= disp_op_d;
      disp_imm_q    <= disp_imm_d;
      disp_pc_q     <= disp_pc_d;
      disp_rd_q     <= disp_rd_d;
      disp_tag_q    <= disp_tag_d;
      disp_qj_q     <= disp_qj_d;
      disp_vj_q     <= disp_vj_d;
      disp_qk_q     <= disp_qk_d;
      disp_vk_q     <= disp_vk_d;
    end else begin
      mem_q         <= mem_q;
      head_q        <= head_q;
      tail_q        <= tail_q;
      count_q       <= count_q;
      disp_valid_q  <= disp_valid_q;
      disp_to_lsb_q <= disp_to_lsb_q;
      disp_op_q     <= disp_op_q;
      disp_imm_q    <= disp_imm_q;
      disp_pc_q     <= disp_pc_q;
      disp_rd_q     <= disp_rd_q;
      disp_tag_q    <= disp_tag_q;
      disp_qj_q     <= disp_qj_q;
      disp_vj_q     <= disp_vj_q;
      disp_qk_q     <= disp_qk_q;
      disp_vk_q     <= disp_vk_q;
    end
  end

  // A pending operand woken by the CDB while the packet is on the wire is patched on the way out.
  always_comb begin
    snoop_j_s       = cdb_lookup(disp_vj_q[ROB_W-1:0], cdb_valid_in, cdb_tag_in, cdb_data_in);
    snoop_k_s       = cdb_lookup(disp_vk_q[ROB_W-1:0], cdb_valid_in, cdb_tag_in, cdb_data_in);
    disp_valid_out  = disp_valid_q;
    disp_to_lsb_out = disp_to_lsb_q;
    disp_op_out     = disp_op_q;
    disp_imm_out    = disp_imm_q;
    disp_pc_out     = disp_pc_q;
    disp_rd_out     = disp_rd_q;
    disp_tag_out    = disp_tag_q;
    if (disp_valid_q && disp_qj_q && snoop_j_s[XLEN]) begin
      disp_qj_out = 1'b0;
      disp_vj_out = snoop_j_s[XLEN-1:0];
    end else begin
      disp_qj_out = disp_qj_q;
      disp_vj_out = disp_vj_q;
    end
    if (disp_valid_q && disp_qk_q && snoop_k_s[XLEN]) begin
      disp_qk_out = 1'b0;
      disp_vk_out = snoop_k_s[XLEN-1:0];
    end else begin
      disp_qk_out = disp_qk_q;
      disp_vk_out = disp_vk_q;
    end
  end

endmodule
